// File: rtl/booth_mul_seq_if.sv
// Request/response bundle for the sequential Booth multiplier.
// The is_unsigned member only exists when MUL_UNSIGNED_EN is defined.
interface booth_mul_seq_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [WIDTH-1:0] M;
    logic [WIDTH-1:0] Q;
`ifdef MUL_UNSIGNED_EN
    logic             is_unsigned;
`endif
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start,
        output M,
        output Q,
`ifdef MUL_UNSIGNED_EN
        output is_unsigned,
`endif
        input  busy,
        input  done,
        input  hi,
        input  lo
    );

    modport slave (
        input  start,
        input  M,
        input  Q,
`ifdef MUL_UNSIGNED_EN
        input  is_unsigned,
`endif
        output busy,
        output done,
        output hi,
        output lo
    );
endinterface

// File: rtl/booth_mul_seq.sv
// Sequential radix-2 Booth multiplier, WIDTH x WIDTH -> 2*WIDTH split into hi/lo.
// Optional MUL_UNSIGNED_EN adds an is_unsigned operand mode (one extra step).
module booth_mul_seq #(
    parameter int WIDTH = 32
) (
    input logic              clock,
    input logic              clear_n,
    booth_mul_seq_if.slave   bus
);

`ifdef MUL_UNSIGNED_EN
    // One spare bit for zero-extended operands, one more for the -M headroom.
    localparam int AW = WIDTH + 2;
    localparam int QW = WIDTH + 1;
`else
    localparam int AW = WIDTH + 1;
    localparam int QW = WIDTH;
`endif
    localparam int CW = $clog2(WIDTH + 2);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_reg;
    logic [AW-1:0]    a_reg;
    logic [AW-1:0]    mr_reg;
    logic [QW-1:0]    qr_reg;
    logic             q1_reg;
    logic [CW-1:0]    cnt_reg;
    logic             busy_reg;
    logic             done_reg;
    logic [WIDTH-1:0] hi_reg;
    logic [WIDTH-1:0] lo_reg;
`ifdef MUL_UNSIGNED_EN
    logic             uns_reg;
`endif

    logic [AW-1:0]      sum_next;
    logic [AW-1:0]      a_next;
    logic [QW-1:0]      qr_next;
    logic [CW-1:0]      last_cnt;
    logic [2*WIDTH-1:0] prod_next;

    always_comb begin
        case ({qr_reg[0], q1_reg})
            2'b01:   sum_next = a_reg + mr_reg;
            2'b10:   sum_next = a_reg - mr_reg;
            default: sum_next = a_reg;
        endcase
        a_next  = {sum_next[AW-1], sum_next[AW-1:1]};
        qr_next = {sum_next[0], qr_reg[QW-1:1]};
`ifdef MUL_UNSIGNED_EN
        // Signed runs stop one step early, leaving the unused top multiplier bit in qr[0].
        if (uns_reg) begin
            last_cnt  = CW'(WIDTH);
            prod_next = {a_next[WIDTH-2:0], qr_next};
        end else begin
            last_cnt  = CW'(WIDTH - 1);
            prod_next = {a_next[WIDTH-1:0], qr_next[QW-1:1]};
        end
`else
        last_cnt  = CW'(WIDTH - 1);
        prod_next = {a_next[WIDTH-1:0], qr_next};
`endif
    end

    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            state_reg <= IDLE;
            a_reg     <= '0;
            mr_reg    <= '0;
            qr_reg    <= '0;
            q1_reg    <= 1'b0;
            cnt_reg   <= '0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
            hi_reg    <= '0;
            lo_reg    <= '0;
`ifdef MUL_UNSIGNED_EN
            uns_reg   <= 1'b0;
`endif
        end else begin
            case (state_reg)
                IDLE: begin
                    if (bus.start) begin
                        state_reg <= RUN;
                        busy_reg  <= 1'b1;
                        a_reg     <= '0;
                        q1_reg    <= 1'b0;
                        cnt_reg   <= '0;
`ifdef MUL_UNSIGNED_EN
                        uns_reg   <= bus.is_unsigned;
                        if (bus.is_unsigned) begin
                            mr_reg <= {2'b00, bus.M};
                            qr_reg <= {1'b0, bus.Q};
                        end else begin
                            mr_reg <= {{2{bus.M[WIDTH-1]}}, bus.M};
                            qr_reg <= {bus.Q[WIDTH-1], bus.Q};
                        end
`else
                        mr_reg    <= {bus.M[WIDTH-1], bus.M};
                        qr_reg    <= bus.Q;
`endif
                    end
                end
                RUN: begin
                    a_reg   <= a_next;
                    qr_reg  <= qr_next;
                    q1_reg  <= qr_reg[0];
                    cnt_reg <= cnt_reg + 1'b1;
                    if (cnt_reg == last_cnt) begin
                        state_reg <= DONE;
                        done_reg  <= 1'b1;
                        hi_reg    <= prod_next[2*WIDTH-1:WIDTH];
                        lo_reg    <= prod_next[WIDTH-1:0];
                    end
                end
                DONE: begin
                    state_reg <= IDLE;
                    busy_reg  <= 1'b0;
                    done_reg  <= 1'b0;
                end
                default: begin
                    state_reg <= IDLE;
                    busy_reg  <= 1'b0;
                    done_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy = busy_reg;
    assign bus.done = done_reg;
    assign bus.hi   = hi_reg;
    assign bus.lo   = lo_reg;

endmodule

// File: tb/tb_booth_mul_seq.sv
// Directed self-checking bench for booth_mul_seq; unsigned cases run only with MUL_UNSIGNED_EN.
module tb_booth_mul_seq;

    logic clock;
    logic clear_n;
    int   checks;
    int   failures;

    booth_mul_seq_if #(.WIDTH(32)) bus ();

    booth_mul_seq #(.WIDTH(32)) dut (
        .clock   (clock),
        .clear_n (clear_n),
        .bus     (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Issue one op with a one-cycle start pulse; lat = edges after accept until done is seen.
    task automatic do_op(input logic [31:0] m, input logic [31:0] q, input logic uns,
                         output logic [31:0] rh, output logic [31:0] rl,
                         output int lat, output int hs_bad);
        @(negedge clock);
        bus.M = m;
        bus.Q = q;
`ifdef MUL_UNSIGNED_EN
        bus.is_unsigned = uns;
`else
        if (uns) hs_bad = 0;
`endif
        bus.start = 1'b1;
        @(posedge clock);
        @(negedge clock);
        bus.start = 1'b0;
        lat = -1;
        hs_bad = 0;
        rh = '0;
        rl = '0;
        if (bus.busy !== 1'b1) hs_bad++;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clock);
            @(negedge clock);
            if (bus.busy !== 1'b1) hs_bad++;
            if (bus.done === 1'b1) begin
                lat = k;
                rh = bus.hi;
                rl = bus.lo;
                break;
            end
        end
        if (lat >= 0) begin
            @(posedge clock);
            @(negedge clock);
            if (bus.done !== 1'b0 || bus.busy !== 1'b0) hs_bad++;
        end
        $display("op M=%h Q=%h uns=%0d -> hi=%h lo=%h lat=%0d hs_bad=%0d", m, q, uns, rh, rl, lat, hs_bad);
    endtask

    task automatic test_reset();
        clear_n = 1'b0;
        bus.start = 1'b0;
        bus.M = '0;
        bus.Q = '0;
`ifdef MUL_UNSIGNED_EN
        bus.is_unsigned = 1'b0;
`endif
        repeat (3) @(posedge clock);
        @(negedge clock);
        checks++;
        if ({bus.busy, bus.done, bus.hi, bus.lo} !== 66'd0) begin
            failures++;
            $display("FAIL reset_state: got busy=%b done=%b hi=%h lo=%h, want all 0", bus.busy, bus.done, bus.hi, bus.lo);
        end
        clear_n = 1'b1;
        $display("reset released");
    endtask

    task automatic test_basic();
        logic [31:0] rh, rl;
        int lat, bad;
        do_op(32'd7, 32'hFFFF_FFFD, 1'b0, rh, rl, lat, bad);
        checks++;
        if (rh !== 32'hFFFF_FFFF) begin failures++; $display("FAIL basic_hi: got %h want ffffffff", rh); end
        checks++;
        if (rl !== 32'hFFFF_FFEB) begin failures++; $display("FAIL basic_lo: got %h want ffffffeb", rl); end
        checks++;
        if (lat !== 32) begin failures++; $display("FAIL basic_latency: got %0d want 32", lat); end
        checks++;
        if (bad !== 0) begin failures++; $display("FAIL basic_handshake: %0d busy/done violations, want 0", bad); end
    endtask

    task automatic test_corners();
        logic [31:0] rh, rl;
        int lat, bad;
        do_op(32'h8000_0000, 32'h8000_0000, 1'b0, rh, rl, lat, bad);
        checks++;
        if ({rh, rl} !== 64'h4000_0000_0000_0000 || lat !== 32) begin
            failures++;
            $display("FAIL min_x_min: got %h_%h lat=%0d want 40000000_00000000 lat=32", rh, rl, lat);
        end
        do_op(32'h7FFF_FFFF, 32'h8000_0000, 1'b0, rh, rl, lat, bad);
        checks++;
        if ({rh, rl} !== 64'hC000_0000_8000_0000) begin
            failures++;
            $display("FAIL max_x_min: got %h_%h want c0000000_80000000", rh, rl);
        end
        do_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, rh, rl, lat, bad);
        checks++;
        if ({rh, rl} !== 64'h0000_0000_0000_0001 || lat !== 32) begin
            failures++;
            $display("FAIL neg1_sq_signed: got %h_%h lat=%0d want 00000000_00000001 lat=32", rh, rl, lat);
        end
    endtask

`ifdef MUL_UNSIGNED_EN
    task automatic test_unsigned();
        logic [31:0] rh, rl;
        int lat, bad;
        do_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, rh, rl, lat, bad);
        checks++;
        if ({rh, rl} !== 64'hFFFF_FFFE_0000_0001) begin
            failures++;
            $display("FAIL unsigned_product: got %h_%h want fffffffe_00000001", rh, rl);
        end
        checks++;
        if (lat !== 33 || bad !== 0) begin
            failures++;
            $display("FAIL unsigned_latency: got lat=%0d bad=%0d want lat=33 bad=0", lat, bad);
        end
        do_op(32'h8000_0000, 32'd2, 1'b1, rh, rl, lat, bad);
        checks++;
        if ({rh, rl} !== 64'h0000_0001_0000_0000) begin
            failures++;
            $display("FAIL unsigned_big_m: got %h_%h want 00000001_00000000", rh, rl);
        end
    endtask
`endif

    task automatic test_ignore_start();
        int lat;
        int extra_done;
        logic [31:0] rh, rl;
        lat = -1;
        extra_done = 0;
        rh = '0;
        rl = '0;
        @(negedge clock);
        bus.M = 32'd100;
        bus.Q = 32'd3;
        bus.start = 1'b1;
        @(posedge clock);
        @(negedge clock);
        bus.start = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            if (k == 5 || k == 20) begin
                bus.start = 1'b1;
                bus.M = 32'd9;
                bus.Q = 32'd9;
            end else begin
                bus.start = 1'b0;
                bus.M = ~bus.M;
                bus.Q = bus.Q + 32'd17;
            end
            @(posedge clock);
            @(negedge clock);
            if (bus.done === 1'b1) begin
                lat = k;
                rh = bus.hi;
                rl = bus.lo;
                break;
            end
        end
        bus.start = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clock);
            @(negedge clock);
            if (bus.done === 1'b1 || bus.busy === 1'b1) extra_done++;
        end
        $display("ignore_start: hi=%h lo=%h lat=%0d extra=%0d", rh, rl, lat, extra_done);
        checks++;
        if ({rh, rl} !== 64'd300 || lat !== 32) begin
            failures++;
            $display("FAIL ignore_start_result: got %h_%h lat=%0d want 00000000_0000012c lat=32", rh, rl, lat);
        end
        checks++;
        if (extra_done !== 0) begin
            failures++;
            $display("FAIL ignore_start_no_second: got %0d busy/done cycles after op, want 0", extra_done);
        end
    endtask

    task automatic test_reset_midrun();
        logic [31:0] rh, rl;
        int lat, bad;
        @(negedge clock);
        bus.M = 32'd123;
        bus.Q = 32'd456;
        bus.start = 1'b1;
        @(posedge clock);
        @(negedge clock);
        bus.start = 1'b0;
        repeat (10) @(posedge clock);
        #2;
        clear_n = 1'b0;
        #1;
        $display("midrun reset: busy=%b done=%b hi=%h lo=%h", bus.busy, bus.done, bus.hi, bus.lo);
        checks++;
        if ({bus.busy, bus.done, bus.hi, bus.lo} !== 66'd0) begin
            failures++;
            $display("FAIL midrun_reset: got busy=%b done=%b hi=%h lo=%h, want all 0", bus.busy, bus.done, bus.hi, bus.lo);
        end
        @(negedge clock);
        clear_n = 1'b1;
        do_op(32'd5, 32'd6, 1'b0, rh, rl, lat, bad);
        checks++;
        if ({rh, rl} !== 64'd30 || lat !== 32 || bad !== 0) begin
            failures++;
            $display("FAIL after_reset_op: got %h_%h lat=%0d bad=%0d want 00000000_0000001e lat=32 bad=0", rh, rl, lat, bad);
        end
    endtask

    task automatic test_back_to_back();
        int first_done;
        int second_done;
        int hold_bad;
        int idle_edge;
        logic [63:0] r1;
        logic [63:0] r2;
        first_done = -1;
        second_done = -1;
        hold_bad = 0;
        idle_edge = -1;
        r1 = '0;
        r2 = '0;
        @(negedge clock);
        bus.M = 32'd3;
        bus.Q = 32'd4;
        bus.start = 1'b1;
        @(posedge clock);
        @(negedge clock);
        bus.M = 32'd0;
        bus.Q = 32'hFFFF_FFFF;
        for (int k = 1; k <= 80; k++) begin
            @(posedge clock);
            @(negedge clock);
            if (first_done >= 0 && second_done < 0 && bus.done !== 1'b1 &&
                {bus.hi, bus.lo} !== 64'd12) hold_bad++;
            if (bus.busy === 1'b0 && idle_edge < 0) idle_edge = k;
            if (idle_edge >= 0 && bus.busy === 1'b1) bus.start = 1'b0;
            if (bus.done === 1'b1) begin
                if (first_done < 0) begin
                    first_done = k;
                    r1 = {bus.hi, bus.lo};
                end else begin
                    second_done = k;
                    r2 = {bus.hi, bus.lo};
                    break;
                end
            end
        end
        bus.start = 1'b0;
        $display("back_to_back: done1=%0d r1=%h idle=%0d done2=%0d r2=%h hold_bad=%0d",
                 first_done, r1, idle_edge, second_done, r2, hold_bad);
        checks++;
        if (first_done !== 32 || r1 !== 64'd12) begin
            failures++;
            $display("FAIL b2b_first: got done at %0d value %h, want 32 and 000000000000000c", first_done, r1);
        end
        checks++;
        if (idle_edge !== 33) begin
            failures++;
            $display("FAIL b2b_idle_gap: got busy low at edge %0d, want 33", idle_edge);
        end
        checks++;
        if (second_done !== 66 || r2 !== 64'd0) begin
            failures++;
            $display("FAIL b2b_second: got done at %0d value %h, want 66 and 0000000000000000", second_done, r2);
        end
        checks++;
        if (hold_bad !== 0) begin
            failures++;
            $display("FAIL b2b_hold: got %0d cycles where hi/lo left 12, want 0", hold_bad);
        end
        repeat (3) @(posedge clock);
    endtask

    initial begin
        checks = 0;
        failures = 0;
        test_reset();
        test_basic();
        test_corners();
`ifdef MUL_UNSIGNED_EN
        test_unsigned();
`endif
        test_ignore_start();
        test_reset_midrun();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
